// File: rtl/ram_np_pkg.sv
// Shared types and helpers for the ram_np multi-port RAM.
// The response record is sized for the widest supported word; narrower RAMs zero-extend into it.
package ram_np_pkg;

    localparam int RamNpMaxPorts   = 4;
    localparam int RamNpMaxLatency = 4;
    localparam int RamNpMaxBytes   = 16;

    function automatic int ram_np_data_w(input int bytes);
        return bytes * 8;
    endfunction

    localparam int RamNpDataW = ram_np_data_w(RamNpMaxBytes);

    typedef struct packed {
        logic                  valid;
        logic                  err;
        logic [RamNpDataW-1:0] data;
    } ram_np_rsp_t;

    function automatic logic [RamNpDataW-1:0] ram_np_bmask(input logic [RamNpMaxBytes-1:0] be);
        logic [RamNpDataW-1:0] m;
        m = '0;
        for (int b = 0; b < RamNpMaxBytes; b++) begin
            m[b*8 +: 8] = {8{be[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/ram_np_rsp_pipe.sv
// Per-port response delay line: Stages register slices carrying {valid, err, data}.
// Stages == 0 is a plain wire; every stage clears on the asynchronous reset.
module ram_np_rsp_pipe
    import ram_np_pkg::*;
#(
    parameter int Stages = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  ram_np_rsp_t rsp_i,
    output ram_np_rsp_t rsp_o
);

    if (Stages == 0) begin : g_bypass
        logic w_unused_clk;
        assign w_unused_clk = clk_i ^ rst_i;
        assign rsp_o        = rsp_i;
    end else begin : g_stages
        ram_np_rsp_t r_stage [Stages];

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                for (int s = 0; s < Stages; s++) begin
                    r_stage[s] <= '0;
                end
            end else begin
                r_stage[0] <= rsp_i;
                for (int s = 1; s < Stages; s++) begin
                    r_stage[s] <= r_stage[s-1];
                end
            end
        end

        assign rsp_o = r_stage[Stages-1];
    end

endmodule

// File: rtl/ram_np.sv
// Parametrised multi-port synchronous RAM with byte enables, range errors and a fixed-latency response pipe.
// Optional macro RAM_NP_WRITE_FIRST_EN: reads see same-cycle writes (merged post-write word).
module ram_np
    import ram_np_pkg::*;
#(
    parameter int    NumPorts    = 2,
    parameter int    Width       = 32,
    parameter int    Depth       = 128,
    parameter int    ReadLatency = 1,
    parameter string MemInitFile = ""
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NumPorts-1:0]         req_i,
    input  logic [NumPorts-1:0]         we_i,
    input  logic [NumPorts*Width/8-1:0] be_i,
    input  logic [NumPorts*32-1:0]      addr_i,
    input  logic [NumPorts*Width-1:0]   wdata_i,
    output logic [NumPorts-1:0]         rvalid_o,
    output logic [NumPorts*Width-1:0]   rdata_o,
    output logic [NumPorts-1:0]         err_o
);

    localparam int NumBytes = Width / 8;
    localparam int OffW     = $clog2(NumBytes);
    localparam int AW       = $clog2(Depth);

    if (Width % 8 != 0) begin : g_chk_width
        $error("ram_np: Width must be a multiple of 8");
    end
    if (Width > RamNpDataW) begin : g_chk_wmax
        $error("ram_np: Width exceeds the response record width");
    end
    if (ReadLatency < 1 || ReadLatency > RamNpMaxLatency) begin : g_chk_lat
        $error("ram_np: ReadLatency out of range");
    end
    if (NumPorts < 1 || NumPorts > RamNpMaxPorts) begin : g_chk_ports
        $error("ram_np: NumPorts out of range");
    end
    if (Depth < 2) begin : g_chk_depth
        $error("ram_np: Depth must be at least 2");
    end

    // Handshake: every req_i is accepted in its cycle (no grant, no back-pressure);
    // rvalid_o pulses for exactly one cycle ReadLatency cycles later, with err_o/rdata_o qualified by it.
    logic [Width-1:0]  r_mem     [Depth];
    logic [AW-1:0]     w_idx     [NumPorts];
    logic              w_oor     [NumPorts];
    logic              w_wr      [NumPorts];
    logic [Width-1:0]  w_rword   [NumPorts];
    ram_np_rsp_t       r_rsp0    [NumPorts];
    ram_np_rsp_t       w_rsp_out [NumPorts];
    logic [NumPorts-1:0] w_unused_rsp;
    logic              w_unused_addr;

    assign w_unused_addr = ^addr_i;

    always_comb begin
        for (int p = 0; p < NumPorts; p++) begin
            w_idx[p] = addr_i[p*32+OffW +: AW];
            w_oor[p] = (int'(w_idx[p]) >= Depth);
            w_wr[p]  = req_i[p] & we_i[p] & ~w_oor[p] & ~rst_i;
        end
    end

    always_comb begin
`ifdef RAM_NP_WRITE_FIRST_EN
        logic [Width-1:0] w_mask;
        w_mask = '0;
`endif
        for (int p = 0; p < NumPorts; p++) begin
            w_rword[p] = w_oor[p] ? '0 : r_mem[w_idx[p]];
`ifdef RAM_NP_WRITE_FIRST_EN
            // Walk high to low so the lowest-index writer lands last and wins each lane.
            for (int q = NumPorts - 1; q >= 0; q--) begin
                if (w_wr[q] && !w_oor[p] && (w_idx[q] == w_idx[p])) begin
                    w_mask     = Width'(ram_np_bmask(RamNpMaxBytes'(be_i[q*NumBytes +: NumBytes])));
                    w_rword[p] = (w_rword[p] & ~w_mask) | (wdata_i[q*Width +: Width] & w_mask);
                end
            end
`endif
        end
    end

    // Non-blocking updates in high-to-low port order: lowest port with be set owns the lane.
    always_ff @(posedge clk_i) begin
        for (int p = NumPorts - 1; p >= 0; p--) begin
            if (w_wr[p]) begin
                for (int b = 0; b < NumBytes; b++) begin
                    if (be_i[p*NumBytes+b]) begin
                        r_mem[w_idx[p]][b*8 +: 8] <= wdata_i[p*Width + b*8 +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int p = 0; p < NumPorts; p++) begin
                r_rsp0[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NumPorts; p++) begin
                r_rsp0[p].valid <= req_i[p];
                r_rsp0[p].err   <= req_i[p] & w_oor[p];
                r_rsp0[p].data  <= req_i[p] ? RamNpDataW'(w_rword[p]) : '0;
            end
        end
    end

    for (genvar p = 0; p < NumPorts; p++) begin : g_port
        ram_np_rsp_pipe #(
            .Stages(ReadLatency - 1)
        ) u_pipe (
            .clk_i(clk_i),
            .rst_i(rst_i),
            .rsp_i(r_rsp0[p]),
            .rsp_o(w_rsp_out[p])
        );

        assign rvalid_o[p]                = w_rsp_out[p].valid;
        assign err_o[p]                   = w_rsp_out[p].err;
        assign rdata_o[p*Width +: Width]  = w_rsp_out[p].data[Width-1:0];
        assign w_unused_rsp[p]            = ^w_rsp_out[p].data;
    end

endmodule
